// File: rtl/prog_timer_if.sv
// rtl/prog_timer_if.sv - control/status bundle for prog_timer (PRESC member only with TMR_PRESCALE_EN)
interface prog_timer_if #(
  parameter int CNT_W = 21
`ifdef TMR_PRESCALE_EN
  , parameter int PRESC_W = 8
`endif
);
  logic             start_tmr;
  logic             stop_tmr;
  logic             mode;
  logic [CNT_W-1:0] period;
`ifdef TMR_PRESCALE_EN
  logic [PRESC_W-1:0] presc;
`endif
  logic             busy;
  logic             pulse;
  logic [CNT_W-1:0] count;

  modport master (
    output start_tmr, stop_tmr, mode, period,
`ifdef TMR_PRESCALE_EN
    output presc,
`endif
    input  busy, pulse, count
  );

  modport slave (
    input  start_tmr, stop_tmr, mode, period,
`ifdef TMR_PRESCALE_EN
    input  presc,
`endif
    output busy, pulse, count
  );
endinterface

// File: rtl/prog_timer.sv
// rtl/prog_timer.sv - programmable one-shot/periodic interval timer with single-cycle expiry pulse
// Optional clock prescaler enabled by defining TMR_PRESCALE_EN.
module prog_timer #(
  parameter int CNT_W = 21
`ifdef TMR_PRESCALE_EN
  , parameter int PRESC_W = 8
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  prog_timer_if.slave io_tmr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;
  logic             w_tick;
  logic             w_accept;

`ifdef TMR_PRESCALE_EN
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] w_presc_nxt;
  logic [PRESC_W-1:0] r_div;
  logic [PRESC_W-1:0] w_div_nxt;

  assign w_tick = (r_presc == r_div);
`else
  assign w_tick = 1'b1;
`endif

  // Stop always wins over start, whatever the state.
  assign w_accept = io_tmr.start_tmr & ~io_tmr.stop_tmr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_period <= '0;
      r_mode   <= 1'b0;
      r_pulse  <= 1'b0;
`ifdef TMR_PRESCALE_EN
      r_presc  <= '0;
      r_div    <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_mode   <= w_mode_nxt;
      r_pulse  <= w_pulse_nxt;
`ifdef TMR_PRESCALE_EN
      r_presc  <= w_presc_nxt;
      r_div    <= w_div_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_mode_nxt   = r_mode;
    w_pulse_nxt  = 1'b0;
`ifdef TMR_PRESCALE_EN
    w_presc_nxt  = r_presc;
    w_div_nxt    = r_div;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = ST_COUNT;
          w_cnt_nxt    = '0;
          w_period_nxt = io_tmr.period;
          w_mode_nxt   = io_tmr.mode;
`ifdef TMR_PRESCALE_EN
          w_presc_nxt  = '0;
          w_div_nxt    = io_tmr.presc;
`endif
        end
      end
      ST_COUNT: begin
        if (io_tmr.stop_tmr) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
`ifdef TMR_PRESCALE_EN
          w_presc_nxt = '0;
`endif
        end else begin
`ifdef TMR_PRESCALE_EN
          w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
`endif
          if (w_tick) begin
            if (r_cnt == r_period) begin
              w_pulse_nxt = 1'b1;
              w_cnt_nxt   = '0;
              if (!r_mode) w_state_nxt = ST_IDLE;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          // A restart overrides the count update but keeps an expiry pulse already due.
          if (io_tmr.start_tmr) begin
            w_state_nxt  = ST_COUNT;
            w_cnt_nxt    = '0;
            w_period_nxt = io_tmr.period;
            w_mode_nxt   = io_tmr.mode;
`ifdef TMR_PRESCALE_EN
            w_presc_nxt  = '0;
            w_div_nxt    = io_tmr.presc;
`endif
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
`ifdef TMR_PRESCALE_EN
        w_presc_nxt = '0;
`endif
      end
    endcase
  end

  assign io_tmr.busy  = (r_state == ST_COUNT);
  assign io_tmr.pulse = r_pulse;
  assign io_tmr.count = r_cnt;

endmodule

// File: tb/tb_prog_timer.sv
// tb/tb_prog_timer.sv - directed self-checking bench for prog_timer (prescaler case with TMR_PRESCALE_EN)
module tb_prog_timer;
  localparam int CW = 10;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  prog_timer_if #(.CNT_W(CW)) tif ();

  prog_timer #(.CNT_W(CW)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_tmr  (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled on the next edge, which becomes edge 0 of the run.
  task automatic start_timer(input logic m, input int p);
    tif.mode      = m;
    tif.period    = CW'(p);
    tif.start_tmr = 1'b1;
    step();
    tif.start_tmr = 1'b0;
  endtask

  task automatic stop_timer();
    tif.stop_tmr = 1'b1;
    step();
    tif.stop_tmr = 1'b0;
  endtask

  int max_cnt;
  int early_pulse;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    tif.start_tmr = 1'b0;
    tif.stop_tmr  = 1'b0;
    tif.mode      = 1'b0;
    tif.period    = '0;
`ifdef TMR_PRESCALE_EN
    tif.presc     = '0;
`endif
    repeat (3) step();
    check("rst_busy",  32'(tif.busy),  0);
    check("rst_pulse", 32'(tif.pulse), 0);
    check("rst_count", 32'(tif.count), 0);
    rst_n = 1'b1;
    step();

    // One-shot P=5: count 0..5, pulse after edge 6 with busy already low.
    start_timer(1'b0, 5);
    check("os_busy0", 32'(tif.busy), 1);
    check("os_cnt0",  32'(tif.count), 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("os_cnt",   32'(tif.count), 32'(k));
      check("os_nopls", 32'(tif.pulse), 0);
    end
    step();
    check("os_pulse", 32'(tif.pulse), 1);
    check("os_busy6", 32'(tif.busy), 0);
    check("os_cnt6",  32'(tif.count), 0);
    step();
    check("os_pulse_off", 32'(tif.pulse), 0);

    // Periodic P=3: pulses at edges 4 and 8, stop at 10 kills the pulse due at 12.
    start_timer(1'b1, 3);
    for (int k = 1; k <= 9; k++) begin
      step();
      check("per_pulse", 32'(tif.pulse), (k % 4 == 0) ? 1 : 0);
    end
    stop_timer();
    check("per_stop_busy", 32'(tif.busy), 0);
    check("per_stop_cnt",  32'(tif.count), 0);
    for (int k = 11; k <= 13; k++) begin
      step();
      check("per_after_stop", 32'(tif.pulse), 0);
    end

    // Restart: one-shot P=10 started at 0 and again at 7 -> single pulse at 18.
    start_timer(1'b0, 10);
    for (int k = 1; k <= 6; k++) step();
    start_timer(1'b0, 10);
    check("rs_cnt", 32'(tif.count), 0);
    check("rs_busy", 32'(tif.busy), 1);
    for (int k = 8; k <= 17; k++) begin
      step();
      check("rs_nopls", 32'(tif.pulse), 0);
    end
    step();
    check("rs_pulse", 32'(tif.pulse), 1);
    check("rs_busy18", 32'(tif.busy), 0);

    // Stop on the terminal edge suppresses the pulse.
    start_timer(1'b0, 2);
    step();
    step();
    stop_timer();
    check("stop_term_pulse", 32'(tif.pulse), 0);
    check("stop_term_busy",  32'(tif.busy), 0);

    // Start and stop together in idle: stays idle.
    tif.start_tmr = 1'b1;
    tif.stop_tmr  = 1'b1;
    step();
    tif.start_tmr = 1'b0;
    tif.stop_tmr  = 1'b0;
    check("both_busy", 32'(tif.busy), 0);
    step();
    check("both_busy2", 32'(tif.busy), 0);

    // Restart on a terminal edge still issues the pulse.
    start_timer(1'b1, 2);
    step();
    step();
    start_timer(1'b1, 2);
    check("rs_term_pulse", 32'(tif.pulse), 1);
    check("rs_term_cnt",   32'(tif.count), 0);
    check("rs_term_busy",  32'(tif.busy), 1);
    stop_timer();

    // Inputs changed mid-count are ignored until the next start.
    start_timer(1'b0, 4);
    tif.period = CW'(1);
    tif.mode   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("lat_nopls", 32'(tif.pulse), 0);
    end
    step();
    check("lat_pulse", 32'(tif.pulse), 1);
    check("lat_busy",  32'(tif.busy), 0);

    // P=0 periodic: pulse every cycle.
    start_timer(1'b1, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("p0_per_pulse", 32'(tif.pulse), 1);
    end
    stop_timer();
    check("p0_stop_pulse", 32'(tif.pulse), 0);

    // P=0 one-shot: a single pulse one cycle after start.
    start_timer(1'b0, 0);
    step();
    check("p0_os_pulse", 32'(tif.pulse), 1);
    check("p0_os_busy",  32'(tif.busy), 0);
    step();
    check("p0_os_off", 32'(tif.pulse), 0);

    // Maximum period one-shot: count tops out at 1023, never wraps.
    start_timer(1'b0, (1 << CW) - 1);
    max_cnt     = 0;
    early_pulse = 0;
    for (int k = 1; k <= (1 << CW) - 1; k++) begin
      step();
      if (int'(tif.count) > max_cnt) max_cnt = int'(tif.count);
      if (tif.pulse) early_pulse++;
    end
    check("max_top",   32'(max_cnt), 32'((1 << CW) - 1));
    check("max_early", 32'(early_pulse), 0);
    step();
    check("max_pulse", 32'(tif.pulse), 1);
    check("max_cnt0",  32'(tif.count), 0);
    check("max_busy",  32'(tif.busy), 0);

`ifdef TMR_PRESCALE_EN
    // D=2, P=1 one-shot: ticks at edges 3 and 6, pulse after edge 6.
    tif.presc = 8'd2;
    start_timer(1'b0, 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("ps_nopls", 32'(tif.pulse), 0);
      if (k == 3) check("ps_cnt3", 32'(tif.count), 1);
    end
    step();
    check("ps_pulse", 32'(tif.pulse), 1);
    check("ps_busy",  32'(tif.busy), 0);
    tif.presc = '0;
`endif

    // Async reset mid-count clears outputs without waiting for a clock edge.
    start_timer(1'b1, 20);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(tif.busy), 0);
    check("arst_count", 32'(tif.count), 0);
    check("arst_pulse", 32'(tif.pulse), 0);
    step();
    rst_n = 1'b1;
    repeat (25) begin
      step();
      if (tif.pulse || tif.busy) break;
    end
    check("arst_stays_idle", 32'(tif.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
